// File: rtl/energy_slot_controller.sv
// Node-level sequencer for the reward/route-update block: charges radio
// energy, hands received packets to the reward block and grants transmits
// only at the start of the node's own TDMA timeslot.
module energy_slot_controller #(
    parameter int unsigned SLOT_CYCLES  = 16,
    parameter int unsigned NUM_SLOTS    = 32,
    parameter logic [15:0] INIT_ENERGY  = 16'h8000,
    parameter logic [15:0] LOW_E_THRESH = 16'h1000,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pktValid,
    input  logic        iHaveData,
    input  logic [5:0]  mySlot,
    input  logic [2:0]  txHops,
    input  logic        rewardDone,
    input  logic        rewardTx,
    output logic        rewardEn,
    output logic        okToSend,
    output logic [15:0] myEnergy,
    output logic        low_E,
    output logic [5:0]  curSlot,
    output logic        busy,
    output logic [7:0]  dropCount,
    output logic        timeoutErr
);

    localparam int unsigned CYC_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [15:0] RX_COST = 16'h0004;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        WAIT_SLOT = 2'd2,
        SEND      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              slot_start;
    logic              dead;
    logic              rx_chg, tx_chg, drop_inc;
    logic              ren_d, ok_d, terr_d;
    logic [15:0]       tx_cost;
    logic [16:0]       charge_total;
    logic [15:0]       energy_d;

    assign slot_start = (cyc_cnt == '0);
    assign dead       = (myEnergy == 16'h0000);

    // Free-running slot timer: cycle-in-slot counter and slot index
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cyc_cnt <= '0;
            curSlot <= '0;
        end else if (cyc_cnt == CYC_W'(SLOT_CYCLES - 1)) begin
            cyc_cnt <= '0;
            curSlot <= (curSlot == 6'(NUM_SLOTS - 1)) ? 6'd0 : curSlot + 6'd1;
        end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    // FSM state and completion-wait counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, pulse requests and energy-charge requests
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        ren_d    = 1'b0;
        ok_d     = 1'b0;
        terr_d   = 1'b0;
        rx_chg   = 1'b0;
        tx_chg   = 1'b0;
        drop_inc = 1'b0;
        if (dead) begin
            // An exhausted node abandons any work and stays silent
            state_d = IDLE;
        end else begin
            if ((state_q != IDLE) && pktValid) begin
                rx_chg   = 1'b1;
                drop_inc = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pktValid) begin
                        rx_chg  = 1'b1;
                        ren_d   = 1'b1;
                        wait_d  = '0;
                        state_d = WAIT_DONE;
                    end else if (iHaveData) begin
                        state_d = WAIT_SLOT;
                    end
                end
                WAIT_DONE: begin
                    if (rewardDone) begin
                        state_d = rewardTx ? WAIT_SLOT : IDLE;
                    end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end
                WAIT_SLOT: begin
                    if ({1'b0, mySlot} >= 7'(NUM_SLOTS)) begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (slot_start && (curSlot == mySlot)) begin
                        ok_d    = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    tx_chg  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Hop-dependent transmit cost; unknown hop counts pay the farthest rate
    always_comb begin
        case (txHops)
            3'd1:    tx_cost = 16'h0005;
            3'd2:    tx_cost = 16'h0009;
            3'd3:    tx_cost = 16'h0011;
            default: tx_cost = 16'h001b;
        endcase
    end

    assign charge_total = 17'(rx_chg ? RX_COST : 16'h0000) + 17'(tx_chg ? tx_cost : 16'h0000);
    assign energy_d     = ({1'b0, myEnergy} > charge_total) ? (myEnergy - charge_total[15:0]) : 16'h0000;

    // Registered outputs: energy bookkeeping, pulses, busy and drop counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            myEnergy   <= INIT_ENERGY;
            low_E      <= (INIT_ENERGY < LOW_E_THRESH);
            rewardEn   <= 1'b0;
            okToSend   <= 1'b0;
            timeoutErr <= 1'b0;
            busy       <= 1'b0;
            dropCount  <= 8'h00;
        end else begin
            myEnergy   <= energy_d;
            low_E      <= (energy_d < LOW_E_THRESH);
            rewardEn   <= ren_d;
            okToSend   <= ok_d;
            timeoutErr <= terr_d;
            busy       <= (state_d != IDLE);
            if (drop_inc && (dropCount != 8'hFF)) begin
                dropCount <= dropCount + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_energy_slot_controller.sv
// Bench for energy_slot_controller: three instances with different starting
// energy share one stimulus stream and are checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_energy_slot_controller;

    localparam int SLOT_CYCLES = 16;
    localparam int NUM_SLOTS   = 32;
    localparam int TIMEOUT     = 64;
    localparam int LOW_THRESH  = 16'h1000;
    localparam int NINST       = 3;

    localparam int P_IDLE = 0;   // nothing in flight
    localparam int P_DONE = 1;   // reward block working on a packet
    localparam int P_SLOT = 2;   // transmit pending until own slot
    localparam int P_SEND = 3;   // grant cycle

    logic        clk;
    logic        nrst;
    logic        pkt_valid;
    logic        i_have_data;
    logic [5:0]  my_slot;
    logic [2:0]  tx_hops;
    logic        reward_done;
    logic        reward_tx;

    logic        reward_en   [NINST];
    logic        ok_to_send  [NINST];
    logic [15:0] my_energy   [NINST];
    logic        low_e       [NINST];
    logic [5:0]  cur_slot    [NINST];
    logic        busy        [NINST];
    logic [7:0]  drop_count  [NINST];
    logic        timeout_err [NINST];

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        energy_slot_controller #(
            .SLOT_CYCLES (16),
            .NUM_SLOTS   (32),
            .INIT_ENERGY ((g == 0) ? 16'h8000 : ((g == 1) ? 16'h1003 : 16'h0003)),
            .LOW_E_THRESH(16'h1000),
            .TIMEOUT     (64)
        ) u_dut (
            .clk       (clk),
            .nrst      (nrst),
            .pktValid  (pkt_valid),
            .iHaveData (i_have_data),
            .mySlot    (my_slot),
            .txHops    (tx_hops),
            .rewardDone(reward_done),
            .rewardTx  (reward_tx),
            .rewardEn  (reward_en[g]),
            .okToSend  (ok_to_send[g]),
            .myEnergy  (my_energy[g]),
            .low_E     (low_e[g]),
            .curSlot   (cur_slot[g]),
            .busy      (busy[g]),
            .dropCount (drop_count[g]),
            .timeoutErr(timeout_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // cycles since reset release

    int m_e     [NINST];
    int m_drops [NINST];
    int m_phase [NINST];
    int m_dstart[NINST];
    int m_ren   [NINST];
    int m_ok    [NINST];
    int m_terr  [NINST];

    function automatic int init_of(input int g);
        return (g == 0) ? 'h8000 : ((g == 1) ? 'h1003 : 'h0003);
    endfunction

    function automatic int tx_cost(input int hops);
        case (hops)
            1:       return 'h05;
            2:       return 'h09;
            3:       return 'h11;
            default: return 'h1b;
        endcase
    endfunction

    task automatic chk(input string name, input int g, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, g, k, act, exp);
        end
    endtask

    // Advance the model from cycle k to k+1 using the inputs presented now
    task automatic model_step();
        for (int g = 0; g < NINST; g++) begin
            int charge;
            int ph;
            charge    = 0;
            ph        = m_phase[g];
            m_ren[g]  = 0;
            m_ok[g]   = 0;
            m_terr[g] = 0;
            if (m_e[g] == 0) begin
                m_phase[g] = P_IDLE;
            end else begin
                if (ph != P_IDLE && pkt_valid) begin
                    charge += 4;
                    if (m_drops[g] < 255) m_drops[g]++;
                end
                case (ph)
                    P_IDLE: begin
                        if (pkt_valid) begin
                            charge      += 4;
                            m_ren[g]    = 1;
                            m_phase[g]  = P_DONE;
                            m_dstart[g] = k + 1;
                        end else if (i_have_data) begin
                            m_phase[g] = P_SLOT;
                        end
                    end
                    P_DONE: begin
                        if (reward_done) begin
                            m_phase[g] = reward_tx ? P_SLOT : P_IDLE;
                        end else if (k - m_dstart[g] == TIMEOUT - 1) begin
                            m_terr[g]  = 1;
                            m_phase[g] = P_IDLE;
                        end
                    end
                    P_SLOT: begin
                        if (int'(my_slot) >= NUM_SLOTS) begin
                            m_terr[g]  = 1;
                            m_phase[g] = P_IDLE;
                        end else if ((k % SLOT_CYCLES == 0) &&
                                     ((k / SLOT_CYCLES) % NUM_SLOTS == int'(my_slot))) begin
                            m_ok[g]    = 1;
                            m_phase[g] = P_SEND;
                        end
                    end
                    default: begin
                        charge     += tx_cost(int'(tx_hops));
                        m_phase[g] = P_IDLE;
                    end
                endcase
                m_e[g] = (m_e[g] > charge) ? m_e[g] - charge : 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NINST; g++) begin
            chk("myEnergy",   g, int'(my_energy[g]),   m_e[g]);
            chk("low_E",      g, int'(low_e[g]),       int'(m_e[g] < LOW_THRESH));
            chk("curSlot",    g, int'(cur_slot[g]),    (k / SLOT_CYCLES) % NUM_SLOTS);
            chk("busy",       g, int'(busy[g]),        int'(m_phase[g] != P_IDLE));
            chk("dropCount",  g, int'(drop_count[g]),  m_drops[g]);
            chk("rewardEn",   g, int'(reward_en[g]),   m_ren[g]);
            chk("okToSend",   g, int'(ok_to_send[g]),  m_ok[g]);
            chk("timeoutErr", g, int'(timeout_err[g]), m_terr[g]);
        end
    endtask

    task automatic clear_inputs();
        pkt_valid   = 1'b0;
        i_have_data = 1'b0;
        reward_done = 1'b0;
        reward_tx   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        for (int g = 0; g < NINST; g++) begin
            m_e[g]      = init_of(g);
            m_drops[g]  = 0;
            m_phase[g]  = P_IDLE;
            m_dstart[g] = 0;
            m_ren[g]    = 0;
            m_ok[g]     = 0;
            m_terr[g]   = 0;
        end
        k = 0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        compare_all();
    endtask

    task automatic tick();
        model_step();
        k++;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst    = 1'b0;
        my_slot = 6'd0;
        tx_hops = 3'd1;
        clear_inputs();

        // Reset values
        do_reset();
        chk("lit_reset_energy", 0, int'(my_energy[0]), 'h8000);
        chk("lit_reset_lowE",   0, int'(low_e[0]),     0);
        chk("lit_reset_lowE",   2, int'(low_e[2]),     1);
        chk("lit_reset_busy",   0, int'(busy[0]),      0);
        chk("lit_reset_slot",   0, int'(cur_slot[0]),  0);

        // Heartbeat without transmit; also low-energy crossing and RX saturation
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        chk("lit_hb_ren",     0, int'(reward_en[0]), 1);
        chk("lit_hb_energy",  0, int'(my_energy[0]), 'h7FFC);
        chk("lit_low_energy", 1, int'(my_energy[1]), 'h0FFF);
        chk("lit_low_lowE",   1, int'(low_e[1]),     1);
        chk("lit_rx_sat",     2, int'(my_energy[2]), 0);
        tick();
        tick();
        reward_done = 1'b1;
        reward_tx   = 1'b0;
        tick();
        clear_inputs();
        chk("lit_hb_idle", 0, int'(busy[0]), 0);
        tick();

        // Slotted transmit in slot 3 with two hops
        do_reset();
        my_slot   = 6'd3;
        tx_hops   = 3'd2;
        pkt_valid = 1'b1;
        tick();
        pkt_valid   = 1'b0;
        reward_done = 1'b1;
        reward_tx   = 1'b1;
        tick();
        clear_inputs();
        while (k < 49) tick();
        chk("lit_tx_grant", 0, int'(ok_to_send[0]), 1);
        chk("lit_tx_slot",  0, int'(cur_slot[0]),   3);
        tick();
        chk("lit_tx_energy", 0, int'(my_energy[0]), 'h7FF3);
        chk("lit_tx_busy",   0, int'(busy[0]),      0);

        // Drop during WAIT_DONE, then timeout
        do_reset();
        pkt_valid = 1'b1;
        tick();
        tick();
        pkt_valid = 1'b0;
        chk("lit_drop_count",  0, int'(drop_count[0]), 1);
        chk("lit_drop_energy", 0, int'(my_energy[0]),  'h7FF8);
        while (k < 65) tick();
        chk("lit_timeout", 0, int'(timeout_err[0]), 1);
        chk("lit_to_busy", 0, int'(busy[0]),        0);

        // Four-hop transmit drains the 3-unit node; it then ignores packets
        do_reset();
        my_slot     = 6'd1;
        tx_hops     = 3'd4;
        i_have_data = 1'b1;
        tick();
        i_have_data = 1'b0;
        while (k < 18) tick();
        chk("lit_dead_energy", 2, int'(my_energy[2]), 0);
        chk("lit_dead_lowE",   2, int'(low_e[2]),     1);
        chk("lit_tx4_energy",  0, int'(my_energy[0]), 'h7FE5);
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        chk("lit_dead_ren",  2, int'(reward_en[2]), 0);
        chk("lit_dead_busy", 2, int'(busy[2]),      0);
        chk("lit_live_ren",  0, int'(reward_en[0]), 1);
        tick();

        // Invalid slot number
        do_reset();
        my_slot     = 6'd40;
        i_have_data = 1'b1;
        tick();
        i_have_data = 1'b0;
        tick();
        chk("lit_badslot_err",  0, int'(timeout_err[0]), 1);
        chk("lit_badslot_ok",   0, int'(ok_to_send[0]),  0);
        chk("lit_badslot_busy", 0, int'(busy[0]),        0);

        // Continuous packets saturate the drop counter
        do_reset();
        pkt_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        pkt_valid = 1'b0;
        chk("lit_drop_sat", 0, int'(drop_count[0]), 255);

        // Randomized traffic with a reset in the middle of activity
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            pkt_valid   = ($urandom_range(0, 7) == 0);
            i_have_data = ($urandom_range(0, 15) == 0);
            reward_done = ($urandom_range(0, 5) == 0);
            reward_tx   = 1'($urandom_range(0, 1));
            tx_hops     = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) begin
                if ($urandom_range(0, 9) == 0) my_slot = 6'($urandom_range(32, 63));
                else                           my_slot = 6'($urandom_range(0, 3));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
